// File: rtl/down_timer_pkg.sv
// Shared types and constants for the down_timer block.
package down_timer_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int TC_CNT_W = 8;
  localparam logic [TC_CNT_W-1:0] TC_CNT_MAX = 8'd255;

endpackage

// File: rtl/down_timer_if.sv
// Load handshake, control and status bundle for down_timer.
// Carries tc_cnt only when DOWN_TIMER_TC_CNT_EN is defined.
interface down_timer_if #(
  parameter int WIDTH = 8
);

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_value;
  logic             auto_reload;
  logic             pause;
  logic             cancel;
  logic [WIDTH-1:0] count_out;
  logic             busy;
  logic             tc_pulse;
`ifdef DOWN_TIMER_TC_CNT_EN
  logic [down_timer_pkg::TC_CNT_W-1:0] tc_cnt;
`endif

  modport master (
    output load_valid, load_value, auto_reload, pause, cancel,
    input  load_ready, count_out, busy, tc_pulse
`ifdef DOWN_TIMER_TC_CNT_EN
    , input tc_cnt
`endif
  );

  modport slave (
    input  load_valid, load_value, auto_reload, pause, cancel,
    output load_ready, count_out, busy, tc_pulse
`ifdef DOWN_TIMER_TC_CNT_EN
    , output tc_cnt
`endif
  );

endinterface

// File: rtl/down_timer_dp.sv
// Count and reload registers with a non-wrapping decrementer.
module down_timer_dp #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic             reload_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] load_value_i,
  output logic [WIDTH-1:0] count_o,
  output logic             is_one_o
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;

  // Next count/reload selection; zero is never decremented.
  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    if (clear_i) begin
      count_d = ZERO;
    end else if (load_i) begin
      count_d  = load_value_i;
      reload_d = load_value_i;
    end else if (reload_i) begin
      count_d = reload_q;
    end else if (dec_i && (count_q != ZERO)) begin
      count_d = count_q - ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Count and reload registers.
  always_ff @(posedge clk) begin
    if (sclr) begin
      count_q  <= ZERO;
      reload_q <= ZERO;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
    end
  end

  assign count_o  = count_q;
  assign is_one_o = (count_q == ONE);

endmodule

// File: rtl/down_timer.sv
// Loadable down-counter/timer with one-shot and auto-reload modes.
// Define DOWN_TIMER_TC_CNT_EN to add the saturating tc_cnt output.
module down_timer
  import down_timer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         sclr,
  down_timer_if.slave  tif
);

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             tc_q, tc_d;
  logic             load_s, dec_s, reload_s, clear_s;
  logic [WIDTH-1:0] count_s;
  logic             is_one_s;

  down_timer_dp #(.WIDTH(WIDTH)) u_dp (
    .clk          (clk),
    .sclr         (sclr),
    .load_i       (load_s),
    .dec_i        (dec_s),
    .reload_i     (reload_s),
    .clear_i      (clear_s),
    .load_value_i (tif.load_value),
    .count_o      (count_s),
    .is_one_o     (is_one_s)
  );

  // Next-state and datapath control decode.
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    tc_d     = 1'b0;
    load_s   = 1'b0;
    dec_s    = 1'b0;
    reload_s = 1'b0;
    clear_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (tif.load_valid) begin
          load_s = 1'b1;
          // A zero load terminates immediately, regardless of auto_reload.
          if (tif.load_value != {WIDTH{1'b0}}) begin
            state_d = RUN;
            busy_d  = 1'b1;
          end else begin
            tc_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (tif.cancel) begin
          clear_s = 1'b1;
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (tif.pause) begin
          state_d = RUN;
        end else if (!is_one_s) begin
          dec_s = 1'b1;
        end else if (tif.auto_reload) begin
          reload_s = 1'b1;
          tc_d     = 1'b1;
        end else begin
          dec_s   = 1'b1;
          tc_d    = 1'b1;
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        clear_s = 1'b1;
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and status registers.
  always_ff @(posedge clk) begin
    if (sclr) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      tc_q    <= tc_d;
    end
  end

  assign tif.load_ready = (state_q == IDLE);
  assign tif.count_out  = count_s;
  assign tif.busy       = busy_q;
  assign tif.tc_pulse   = tc_q;

`ifdef DOWN_TIMER_TC_CNT_EN
  logic [TC_CNT_W-1:0] tc_cnt_q, tc_cnt_d, tc_base_s;

  // An accepted load restarts the tally before counting its own pulse.
  assign tc_base_s = load_s ? {TC_CNT_W{1'b0}} : tc_cnt_q;
  assign tc_cnt_d  = (tc_d && (tc_base_s != TC_CNT_MAX))
                   ? tc_base_s + {{(TC_CNT_W-1){1'b0}}, 1'b1}
                   : tc_base_s;

  // Saturating terminal-count tally.
  always_ff @(posedge clk) begin
    if (sclr) begin
      tc_cnt_q <= {TC_CNT_W{1'b0}};
    end else begin
      tc_cnt_q <= tc_cnt_d;
    end
  end

  assign tif.tc_cnt = tc_cnt_q;
`endif

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: vector table plus multi-cycle sequences.
module tb_down_timer;

  localparam int W = 8;

  logic clk = 1'b0;
  logic sclr;

  always #5 clk = ~clk;

  down_timer_if #(.WIDTH(W)) tif ();

  down_timer #(.WIDTH(W)) dut (
    .clk  (clk),
    .sclr (sclr),
    .tif  (tif)
  );

  typedef struct {
    logic       s;
    logic       lv;
    logic [7:0] val;
    logic       ar;
    logic       p;
    logic       c;
    logic [7:0] e_cnt;
    logic       e_busy;
    logic       e_tc;
    logic       e_rdy;
  } vec_t;

  typedef struct {
    logic [7:0] cnt;
    logic       busy;
    logic       tc;
    logic       rdy;
    string      tag;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic s, input logic lv, input logic [7:0] val,
                              input logic ar, input logic p, input logic c,
                              input logic [7:0] e_cnt, input logic e_busy,
                              input logic e_tc, input logic e_rdy);
    vec_t v;
    v.s = s; v.lv = lv; v.val = val; v.ar = ar; v.p = p; v.c = c;
    v.e_cnt = e_cnt; v.e_busy = e_busy; v.e_tc = e_tc; v.e_rdy = e_rdy;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    exp_t got;
    @(negedge clk);
    sclr            = v.s;
    tif.load_valid  = v.lv;
    tif.load_value  = v.val;
    tif.auto_reload = v.ar;
    tif.pause       = v.p;
    tif.cancel      = v.c;
    e.cnt = v.e_cnt; e.busy = v.e_busy; e.tc = v.e_tc; e.rdy = v.e_rdy; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      got = sb.pop_front();
      if (tif.count_out !== got.cnt || tif.busy !== got.busy ||
          tif.tc_pulse !== got.tc || tif.load_ready !== got.rdy) begin
        n_err++;
        $display("FAIL %s: got cnt=%0d busy=%0b tc=%0b rdy=%0b, expected cnt=%0d busy=%0b tc=%0b rdy=%0b",
                 got.tag, tif.count_out, tif.busy, tif.tc_pulse, tif.load_ready,
                 got.cnt, got.busy, got.tc, got.rdy);
      end
    end
  endtask

  initial begin
    sclr            = 1'b1;
    tif.load_valid  = 1'b0;
    tif.load_value  = 8'd0;
    tif.auto_reload = 1'b0;
    tif.pause       = 1'b0;
    tif.cancel      = 1'b0;

    // reset with load_valid held high
    vecs.push_back(mk(1'b1, 1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1));
    // one-shot 5
    vecs.push_back(mk(1'b0, 1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 8'd5, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd4, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1));
    // load 6, pause two cycles at 4
    vecs.push_back(mk(1'b0, 1'b1, 8'd6, 1'b0, 1'b0, 1'b0, 8'd6, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd5, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd4, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd4, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd4, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1));
    // auto-reload 3, then drop auto_reload
    vecs.push_back(mk(1'b0, 1'b1, 8'd3, 1'b1, 1'b0, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd3, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd3, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1));
    // load 9 ignored while running, cancel at 2, held load then accepted
    vecs.push_back(mk(1'b0, 1'b1, 8'd4, 1'b0, 1'b0, 1'b0, 8'd4, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 8'd9, 1'b0, 1'b0, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 8'd9, 1'b0, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 8'd9, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 8'd9, 1'b0, 1'b0, 1'b0, 8'd9, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1));
    // pause at count 1 must not terminate
    vecs.push_back(mk(1'b0, 1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1));
    // load 0 is an immediate one-shot even with auto_reload
    vecs.push_back(mk(1'b0, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1));
    // load 10, sclr at 7 (with load_valid high)
    vecs.push_back(mk(1'b0, 1'b1, 8'd10, 1'b0, 1'b0, 1'b0, 8'd10, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd9, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd8, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd7, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 8'd10, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // one-shot at the maximum value: 255 cycles to terminal
    apply(mk(1'b0, 1'b1, 8'd255, 1'b0, 1'b0, 1'b0, 8'd255, 1'b1, 1'b0, 1'b0), "ld255");
    for (int i = 254; i >= 1; i--) begin
      apply(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'(i), 1'b1, 1'b0, 1'b0), "run255");
    end
    apply(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1), "tc255");

    // auto-reload period of 5 over three periods, then cancel
    apply(mk(1'b0, 1'b1, 8'd5, 1'b1, 1'b0, 1'b0, 8'd5, 1'b1, 1'b0, 1'b0), "ld5ar");
    for (int t = 1; t <= 15; t++) begin
      apply(mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'(5 - (t % 5)), 1'b1,
               ((t % 5) == 0) ? 1'b1 : 1'b0, 1'b0), "period5");
    end
    apply(mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1), "cancel5");

`ifdef DOWN_TIMER_TC_CNT_EN
    apply(mk(1'b0, 1'b1, 8'd2, 1'b1, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0), "ld2ar");
    n_cmp++;
    if (tif.tc_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL tc_cnt_clear: got %0d expected 0", tif.tc_cnt);
    end
    for (int t = 1; t <= 600; t++) begin
      apply(mk(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, ((t % 2) == 1) ? 8'd1 : 8'd2, 1'b1,
               ((t % 2) == 0) ? 1'b1 : 1'b0, 1'b0), "tccnt_run");
      if (t == 20) begin
        n_cmp++;
        if (tif.tc_cnt !== 8'd10) begin
          n_err++;
          $display("FAIL tc_cnt_10: got %0d expected 10", tif.tc_cnt);
        end
      end
    end
    n_cmp++;
    if (tif.tc_cnt !== 8'd255) begin
      n_err++;
      $display("FAIL tc_cnt_sat: got %0d expected 255", tif.tc_cnt);
    end
    apply(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1), "cancel2");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
